// File: rtl/coin_stream_encoder_pkg.sv
// Shared types and constants for the coin stream encoder and the payment FSM.
package coin_stream_encoder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        GAP,
        PAY,
        WAIT_FIM
    } state_t;

    // Coin values as seen on I by the payment FSM.
    localparam logic [4:0] COIN_10 = 5'd10;
    localparam logic [4:0] COIN_20 = 5'd20;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle rising-edge pulse.
module edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronize the raw level and keep the previous synchronized value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // A held level yields exactly one pulse.
    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/coin_stream_encoder.sv
// Turns front-panel coin/pay levels into the I/PG stream for the payment FSM.
module coin_stream_encoder
    import coin_stream_encoder_pkg::*;
#(
    parameter int unsigned VAL_W       = 5,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned FIM_TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             coin10_in,
    input  logic             coin20_in,
    input  logic             pay_in,
    input  logic             fim,
    output logic [VAL_W-1:0] I,
    output logic             PG,
    output logic             busy,
    output logic             overflow,
    output logic             timeout
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam int unsigned TW = $clog2(FIM_TIMEOUT + 1);

    localparam logic [VAL_W-1:0] V10      = VAL_W'(COIN_10);
    localparam logic [VAL_W-1:0] V20      = VAL_W'(COIN_20);
    localparam logic [PW:0]      PTR_ONE  = (PW + 1)'(1);
    localparam logic [GW-1:0]    GAP_ONE  = GW'(1);
    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES);
    localparam logic [TW-1:0]    TMO_ONE  = TW'(1);
    // Counter is loaded with 1 for the PG cycle, so expiry lands FIM_TIMEOUT cycles after PG.
    localparam logic [TW-1:0]    TMO_LAST = TW'(FIM_TIMEOUT - 1);

    logic             e10;
    logic             e20;
    logic             epay;

    logic [VAL_W-1:0] mem [FIFO_DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic             skid_valid;
    logic             pay_pending;

    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_req;
    logic             wr_en;
    logic [VAL_W-1:0] wr_val;
    logic             drop;
    logic             pay_start;

    state_t           state;
    logic [GW-1:0]    gap_cnt;
    logic [TW-1:0]    tmo_cnt;

    edge_sync u_sync10 (.clock(clock), .reset(reset), .raw(coin10_in), .pulse(e10));
    edge_sync u_sync20 (.clock(clock), .reset(reset), .raw(coin20_in), .pulse(e20));
    edge_sync u_syncpay (.clock(clock), .reset(reset), .raw(pay_in), .pulse(epay));

    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign pop   = (state == IDLE) && !empty;
    // Any coin still in flight (FIFO, skid or a write this cycle) goes out before PG.
    assign pay_start = (state == IDLE) && empty && pay_pending && !skid_valid && !wr_req;
    assign busy  = (state != IDLE) || !empty || skid_valid || pay_pending;

    // Pick this cycle's FIFO write: skid first, then 10, then 20; flag any dropped coin.
    always_comb begin
        wr_req = 1'b0;
        wr_val = V10;
        drop   = 1'b0;
        if (skid_valid) begin
            wr_req = 1'b1;
            wr_val = V20;
            drop   = e10 | e20;
        end else if (e10) begin
            wr_req = 1'b1;
            wr_val = V10;
        end else if (e20) begin
            wr_req = 1'b1;
            wr_val = V20;
        end
        // A pop in the same cycle frees a slot on a full FIFO.
        wr_en = wr_req && (!full || pop);
        if (wr_req && !wr_en) begin
            drop = 1'b1;
        end
    end

    // Queue pointers, skid, sticky pay request and overflow pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr        <= '0;
            rptr        <= '0;
            skid_valid  <= 1'b0;
            pay_pending <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            // Simultaneous edges park the 20 for one cycle; a busy skid cannot take another.
            skid_valid <= !skid_valid && e10 && e20;
            if (pay_start) begin
                pay_pending <= 1'b0;
            end else if (epay) begin
                pay_pending <= 1'b1;
            end
            overflow <= drop;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wptr[PW-1:0]] <= wr_val;
        end
    end

    // Transmit FSM with registered I, PG and timeout.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            I       <= '0;
            PG      <= 1'b0;
            timeout <= 1'b0;
            gap_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            PG      <= 1'b0;
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        I     <= mem[rptr[PW-1:0]];
                        state <= DRIVE;
                    end else if (pay_start) begin
                        I     <= '0;
                        PG    <= 1'b1;
                        state <= PAY;
                    end else begin
                        I <= '0;
                    end
                end
                DRIVE: begin
                    I       <= '0;
                    gap_cnt <= GAP_ONE;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_ONE;
                    end
                end
                PAY: begin
                    tmo_cnt <= TMO_ONE;
                    state   <= WAIT_FIM;
                end
                WAIT_FIM: begin
                    // fim wins over a same-cycle expiry.
                    if (fim) begin
                        state <= IDLE;
                    end else if (tmo_cnt >= TMO_LAST) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_stream_encoder.sv
// Self-checking bench for coin_stream_encoder: directed scenarios plus a randomized coin stream.
module tb_coin_stream_encoder;

    localparam int unsigned VAL_W = 5;
    localparam logic [VAL_W-1:0] V10 = 5'd10;
    localparam logic [VAL_W-1:0] V20 = 5'd20;

    logic             clock = 1'b0;
    logic             reset;
    logic             coin10_in;
    logic             coin20_in;
    logic             pay_in;
    logic             fim;
    logic [VAL_W-1:0] I;
    logic             PG;
    logic             busy;
    logic             overflow;
    logic             timeout;

    logic             t_pay;
    logic             t_fim;
    logic [VAL_W-1:0] t_I;
    logic             t_PG;
    logic             t_busy;
    logic             t_overflow;
    logic             t_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    coin_stream_encoder #(
        .VAL_W(VAL_W), .FIFO_DEPTH(4), .GAP_CYCLES(1), .FIM_TIMEOUT(255)
    ) dut (
        .clock(clock), .reset(reset), .coin10_in(coin10_in), .coin20_in(coin20_in),
        .pay_in(pay_in), .fim(fim), .I(I), .PG(PG), .busy(busy), .overflow(overflow),
        .timeout(timeout)
    );

    // Short fim timeout instance for the timeout scenarios.
    coin_stream_encoder #(
        .VAL_W(VAL_W), .FIFO_DEPTH(4), .GAP_CYCLES(1), .FIM_TIMEOUT(8)
    ) dut_t (
        .clock(clock), .reset(reset), .coin10_in(1'b0), .coin20_in(1'b0),
        .pay_in(t_pay), .fim(t_fim), .I(t_I), .PG(t_PG), .busy(t_busy),
        .overflow(t_overflow), .timeout(t_timeout)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; coin10_in = 1'b0; coin20_in = 1'b0; pay_in = 1'b0; fim = 1'b0;
        t_pay = 1'b0; t_fim = 1'b0;
        for (int i = 0; i < 3; i++) begin
            coin10_in = 1'($urandom); coin20_in = 1'($urandom);
            pay_in = 1'($urandom); fim = 1'($urandom); t_pay = 1'($urandom);
            tick();
            n_tests++;
            if ({I, PG, busy, overflow, timeout} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got I=%0d PG=%b busy=%b ovf=%b tmo=%b, expected all 0",
                         i, I, PG, busy, overflow, timeout);
            end
        end
        // Release with coin10 high on the first sampling edge.
        reset = 1'b1; coin10_in = 1'b1; coin20_in = 1'b0; pay_in = 1'b0; fim = 1'b0;
        t_pay = 1'b0;
        tick();
        coin10_in = 1'b0;
        tick();
        tick();
        n_tests++;
        if (I !== '0) begin
            n_fail++; $display("FAIL reset_release_k2: got I=%0d, expected 0", I);
        end
        tick();
        n_tests++;
        if (I !== V10) begin
            n_fail++; $display("FAIL reset_release_k3: got I=%0d, expected %0d", I, V10);
        end
        tick();
        n_tests++;
        if (I !== '0) begin
            n_fail++; $display("FAIL reset_release_k4: got I=%0d, expected 0", I);
        end
        repeat (4) tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_drain_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_coin_sequence();
        logic [VAL_W-1:0] exp_q[$];
        logic [VAL_W-1:0] got_q[$];
        int adj;
        logic prev_nz;
        exp_q = '{V10, V10, V20};
        adj = 0; prev_nz = 1'b0;
        for (int c = 0; c < 30; c++) begin
            coin10_in = (c == 0 || c == 5);
            coin20_in = (c == 10);
            tick();
            if (I !== '0) got_q.push_back(I);
            if (I !== '0 && prev_nz) adj++;
            prev_nz = (I !== '0);
        end
        n_tests++;
        if (got_q.size() != 3) begin
            n_fail++; $display("FAIL seq_count: got %0d coins, expected 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL seq_value[%0d]: got %0d, expected %0d", i, got_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (adj != 0) begin
            n_fail++; $display("FAIL seq_adjacent: got %0d adjacent pairs, expected 0", adj);
        end
    endtask

    task automatic test_simultaneous();
        logic [VAL_W-1:0] got_q[$];
        int ovf;
        ovf = 0;
        for (int c = 0; c < 20; c++) begin
            coin10_in = (c == 0);
            coin20_in = (c == 0);
            tick();
            if (I !== '0) got_q.push_back(I);
            if (overflow === 1'b1) ovf++;
        end
        n_tests++;
        if (got_q.size() != 2) begin
            n_fail++; $display("FAIL simul_count: got %0d coins, expected 2", got_q.size());
        end else begin
            n_tests++;
            if (got_q[0] !== V10 || got_q[1] !== V20) begin
                n_fail++;
                $display("FAIL simul_order: got %0d,%0d, expected %0d,%0d", got_q[0], got_q[1], V10, V20);
            end
        end
        n_tests++;
        if (ovf != 0) begin
            n_fail++; $display("FAIL simul_overflow: got %0d pulses, expected 0", ovf);
        end
    endtask

    task automatic test_overflow();
        logic found;
        int ovf, ovf_early, nz, tens;
        pay_in = 1'b1; tick(); pay_in = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick(); found = (PG === 1'b1);
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL ovf_pg_seen: got no PG, expected PG");
        end
        ovf = 0; ovf_early = 0; nz = 0;
        for (int c = 0; c < 15; c++) begin
            coin10_in = (c < 10) && (c % 2 == 0);
            tick();
            if (overflow === 1'b1) begin
                ovf++;
                if (c <= 9) ovf_early++;
            end
            if (I !== '0) nz++;
        end
        n_tests++;
        if (ovf != 1) begin
            n_fail++; $display("FAIL ovf_pulses: got %0d, expected 1", ovf);
        end
        n_tests++;
        if (ovf_early != 0) begin
            n_fail++; $display("FAIL ovf_before_fifth: got %0d, expected 0", ovf_early);
        end
        n_tests++;
        if (nz != 0) begin
            n_fail++; $display("FAIL ovf_sent_in_wait: got %0d coins, expected 0", nz);
        end
        fim = 1'b1; tick(); fim = 1'b0;
        nz = 0; tens = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (I !== '0) nz++;
            if (I === V10) tens++;
        end
        n_tests++;
        if (nz != 4 || tens != 4) begin
            n_fail++; $display("FAIL ovf_drain: got %0d coins (%0d tens), expected 4 (4)", nz, tens);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL ovf_busy_end: got %b, expected 0", busy);
        end
    endtask

    task automatic test_pay_ordering();
        int t_coin, t_pg;
        t_coin = -1; t_pg = -1;
        coin20_in = 1'b1; tick();
        coin20_in = 1'b0; pay_in = 1'b1; tick();
        pay_in = 1'b0;
        for (int c = 2; c < 20 && t_pg < 0; c++) begin
            tick();
            if (I === V20 && t_coin < 0) t_coin = c;
            if (PG === 1'b1) t_pg = c;
        end
        n_tests++;
        if (t_coin != 3) begin
            n_fail++; $display("FAIL pay_coin_latency: got cycle %0d, expected 3", t_coin);
        end
        n_tests++;
        if (t_pg < 0 || t_pg <= t_coin + 1) begin
            n_fail++; $display("FAIL pay_after_gap: got PG cycle %0d, expected > %0d", t_pg, t_coin + 1);
        end
        tick();
        n_tests++;
        if (PG !== 1'b0) begin
            n_fail++; $display("FAIL pay_pg_width: got PG=%b, expected 0", PG);
        end
        fim = 1'b1; tick(); fim = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL pay_fim_idle: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_timeout();
        logic found;
        int tmo_at, early;
        t_pay = 1'b1; tick(); t_pay = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick(); found = (t_PG === 1'b1);
        end
        tmo_at = -1;
        for (int c = 1; c <= 20 && tmo_at < 0; c++) begin
            tick();
            if (t_timeout === 1'b1) tmo_at = c;
        end
        n_tests++;
        if (!found || tmo_at != 8) begin
            n_fail++; $display("FAIL tmo_delay: got %0d cycles after PG (pg=%b), expected 8", tmo_at, found);
        end
        n_tests++;
        if (t_busy !== 1'b0) begin
            n_fail++; $display("FAIL tmo_idle: got busy=%b, expected 0", t_busy);
        end
        tick();
        n_tests++;
        if (t_timeout !== 1'b0) begin
            n_fail++; $display("FAIL tmo_width: got %b, expected 0", t_timeout);
        end
        // fim arrives on the expiry cycle.
        t_pay = 1'b1; tick(); t_pay = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick(); found = (t_PG === 1'b1);
        end
        early = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (t_timeout === 1'b1) early++;
        end
        t_fim = 1'b1; tick(); t_fim = 1'b0;
        n_tests++;
        if (!found || early != 0 || t_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_fim_wins: got timeout=%b early=%0d pg=%b, expected 0 0 1",
                     t_timeout, early, found);
        end
        n_tests++;
        if (t_busy !== 1'b0) begin
            n_fail++; $display("FAIL tmo_fim_idle: got busy=%b, expected 0", t_busy);
        end
        tick();
        n_tests++;
        if (t_timeout !== 1'b0) begin
            n_fail++; $display("FAIL tmo_fim_after: got %b, expected 0", t_timeout);
        end
    endtask

    task automatic test_random();
        bit s10[$];
        bit s20[$];
        bit spay[$];
        logic [VAL_W-1:0] exp_q[$];
        int idx, pgs, ovf;
        logic prev_nz;
        int kind, h, l;
        for (int e = 0; e < 25; e++) begin
            kind = $urandom_range(0, 2);
            h = $urandom_range(1, 3);
            l = (kind == 2) ? $urandom_range(5, 8) : $urandom_range(3, 6);
            for (int j = 0; j < h; j++) begin
                s10.push_back(kind != 1); s20.push_back(kind != 0); spay.push_back(1'b0);
            end
            if (kind != 1) exp_q.push_back(V10);
            if (kind != 0) exp_q.push_back(V20);
            if (e == 24) begin
                s10.push_back(1'b0); s20.push_back(1'b0); spay.push_back(1'b1);
                l = 60;
            end
            for (int j = 0; j < l; j++) begin
                s10.push_back(1'b0); s20.push_back(1'b0); spay.push_back(1'b0);
            end
        end
        idx = 0; pgs = 0; ovf = 0; prev_nz = 1'b0;
        for (int c = 0; c < s10.size(); c++) begin
            coin10_in = s10[c]; coin20_in = s20[c]; pay_in = spay[c];
            tick();
            if (I !== '0) begin
                n_tests++;
                if (idx >= exp_q.size()) begin
                    n_fail++; $display("FAIL rand_extra_coin: got %0d, expected no coin", I);
                end else if (I !== exp_q[idx]) begin
                    n_fail++; $display("FAIL rand_coin[%0d]: got %0d, expected %0d", idx, I, exp_q[idx]);
                end
                idx++;
                n_tests++;
                if (prev_nz) begin
                    n_fail++; $display("FAIL rand_adjacent[%0d]: got back-to-back coins, expected gap", idx);
                end
            end
            prev_nz = (I !== '0);
            if (overflow === 1'b1) ovf++;
            if (PG === 1'b1) begin
                pgs++;
                n_tests++;
                if (idx != exp_q.size()) begin
                    n_fail++; $display("FAIL rand_pg_order: got PG after %0d coins, expected %0d", idx, exp_q.size());
                end
                fim = 1'b1;
            end
        end
        fim = 1'b0;
        n_tests++;
        if (idx != exp_q.size() || pgs != 1) begin
            n_fail++; $display("FAIL rand_totals: got %0d coins %0d PG, expected %0d coins 1 PG",
                               idx, pgs, exp_q.size());
        end
        n_tests++;
        if (ovf != 0) begin
            n_fail++; $display("FAIL rand_overflow: got %0d pulses, expected 0", ovf);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rand_busy_end: got %b, expected 0", busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_coin_sequence();
        test_simultaneous();
        test_overflow();
        test_pay_ordering();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_stream_encoder.md
Name: coin_stream_encoder

Overview:
- Transmit side of the payment interface: converts raw coin-sensor and pay-button levels into the I/PG stream consumed by the payment FSM.
- Drives one coin value per frame on I, separated by I=0 gap cycles, then a one-cycle PG strobe, then waits for the FSM's FIM.
- Sits between the front-panel inputs and the payment FSM's I/PG ports; FIM feeds back into this block.

Parameters:
- VAL_W, 5, width of I.
- FIFO_DEPTH, 4, coin queue entries; power of two, at least 2.
- GAP_CYCLES, 1, cycles of I=0 after each coin value; at least 1.
- FIM_TIMEOUT, 255, cycles to wait for fim after PG before giving up; at least 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- coin10_in  in  1  raw 10-unit coin sensor level, asynchronous.
- coin20_in  in  1  raw 20-unit coin sensor level, asynchronous.
- pay_in  in  1  raw pay-button level, asynchronous.
- fim  in  1  end-of-transaction from the payment FSM.
- I  out  VAL_W  coin value to the payment FSM; 0 = no coin.
- PG  out  1  pay strobe to the payment FSM.
- busy  out  1  high when not IDLE, or when FIFO, skid or pay_pending is non-empty.
- overflow  out  1  one-cycle pulse when a coin is dropped.
- timeout  out  1  one-cycle pulse when the fim wait expires.

Behaviour:
- Reset (reset==0 at a clock edge) clears: I=0, PG=0, busy=0, overflow=0, timeout=0, FIFO, skid, pay_pending, sync/edge flops; state=IDLE. Reset mid-frame aborts the frame with no partial output.
- Input conditioning, per raw input:
  - two-flop synchronizer, then a prev flop; edge = sync2 & ~prev.
  - Only rising edges act; held levels produce one event.
- Coin enqueue:
  - coin10 edge writes 10; coin20 edge writes 20.
  - Simultaneous edges: 10 is written this cycle; 20 goes to a one-entry skid register and is written the next cycle. The skid has priority over new edges that cycle; a colliding new edge is dropped with an overflow pulse.
  - FIFO full at write time: value dropped, overflow=1 for one cycle, FIFO unchanged.
  - Same-cycle write and read on a full FIFO are both allowed (no drop).
- Pay request: a pay edge sets sticky pay_pending; further edges while it is set are ignored.
- Transmit FSM, all outputs registered:
  - IDLE: if FIFO not empty, pop into I and go to DRIVE. Else if pay_pending and skid empty, assert PG, clear pay_pending, go to PAY. Else hold I=0, PG=0.
  - DRIVE: I holds the popped value for exactly one cycle, then I=0 and go to GAP.
  - GAP: I=0 for GAP_CYCLES cycles total, counting the first zero cycle, then go to IDLE. Coins therefore never appear back-to-back on I.
  - PAY: PG high for exactly one cycle, then go to WAIT_FIM and load the timeout counter.
  - WAIT_FIM: I=0, PG=0. Coins still enqueue but are not sent.
    - fim==1: go to IDLE.
    - Counter reaches FIM_TIMEOUT: timeout=1 for one cycle, go to IDLE.
    - fim==1 in the same cycle the counter expires: treat as fim, no timeout pulse.
- Coins always take precedence over a pending pay, so every queued coin is sent before PG.
- Latency: raw coin level first sampled high at edge k gives FIFO write at k+2 and I=value at k+3, when IDLE with an empty FIFO.
- Counters saturate; pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.

Decomposition:
- Shared package:
  - state enum: IDLE, DRIVE, GAP, PAY, WAIT_FIM.
  - coin value constants COIN_10=5'd10 and COIN_20=5'd20, also used by the payment FSM.
- One sub-module: edge_sync, a 2FF synchronizer plus rising-edge pulse, instantiated three times.
- The FIFO stays inline.

Test Plan:
- Reset hold: reset=0 for 3 cycles with all inputs toggling -> I=0, PG=0, busy=0, overflow=0 throughout. Release with coin10 pulsed -> I=10 three cycles after sampling, then I=0.
- Coin sequence: coin10, coin10, coin20 at least 4 cycles apart, GAP_CYCLES=1 -> I shows 10,0,10,0,20,0 with no adjacent non-zero cycles.
- Simultaneous coins: coin10 and coin20 rise on the same edge -> I=10, later I=20 (order fixed), no overflow.
- Overflow: FIFO_DEPTH=4, FSM held in WAIT_FIM, 5 coin10 edges -> exactly one overflow pulse on the 5th. After fim, exactly four 10s are sent.
- Pay ordering: coin20 edge then pay edge one cycle later -> I=20, gap, then PG=1 for one cycle. fim=1 two cycles later -> IDLE, busy=0.
- Timeout: pay with fim held 0, FIM_TIMEOUT=8 -> timeout pulse 8 cycles after PG, then IDLE. Repeat with fim=1 on the expiry cycle -> no timeout pulse.
